div_issue_ctrl: RTL and testbench
=================================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; the attached divider SHALL be the 2*XLEN-dividend / XLEN-divisor non-restoring unsigned divider.
REQ-002 One clock; reset is synchronous and active-low. Ports are listed in the next lines: name, direction, width, meaning.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 resetn  in  1  synchronous active-low reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  divide-request handshake; transfer when both are high at an edge.
REQ-006 req_signed  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-007 req_a, req_b  in  XLEN  dividend and divisor.
REQ-008 div_start  out  1  one-cycle start pulse to the divider.
REQ-009 div_a  out  2*XLEN  magnitude of the dividend, zero-extended.
REQ-010 div_b  out  XLEN  magnitude of the divisor.
REQ-011 div_busy  in  1  divider busy flag.
REQ-012 div_q, div_r  in  2*XLEN, XLEN  unsigned quotient and remainder from the divider.
REQ-013 hi, lo  out  XLEN  remainder and quotient registers.
REQ-014 res_valid  out  1  one-cycle pulse when hi/lo have just been written.
REQ-015 stall  out  1  high whenever the state is not IDLE.
REQ-016 dz  out  1  divide-by-zero flag of the last result; valid with res_valid.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT and FIX; req_ready = (state == IDLE).
REQ-018 IDLE, on handshake with req_b != 0: latch operand magnitudes (absolute value when req_signed, raw value otherwise), qneg = signed & (a_msb ^ b_msb), rneg = signed & a_msb; go to ISSUE.
REQ-019 IDLE, on handshake with req_b == 0: go directly to FIX with dz set; the divider is never started.
REQ-020 ISSUE: div_start = 1 for exactly one cycle; div_a and div_b are held stable from the latch until FIX; go to WAIT at the next edge.
REQ-021 WAIT: remain while div_busy = 1; go to FIX at the first edge with div_busy = 0; div_busy is not sampled in ISSUE.
REQ-022 FIX, normal divide: lo <= qneg ? -div_q[XLEN-1:0] : div_q[XLEN-1:0]; hi <= rneg ? -div_r : div_r; all arithmetic is modulo 2^XLEN.
REQ-023 FIX, divide by zero: lo <= all ones; hi <= req_a as latched; dz <= 1.
REQ-024 FIX SHALL always go to IDLE and assert res_valid in the following cycle; dz <= 0 on every normal result.
REQ-025 Latency, normal divide: res_valid is high in the cycle after edge 2*XLEN+3, counting the accept edge as edge 0 (edge 67 for XLEN = 32).
REQ-026 Latency, divide by zero: res_valid is high in the cycle after edge 1.
REQ-027 A request offered during the res_valid cycle SHALL be accepted, giving back-to-back operation with no bubble.
REQ-028 Signed overflow (most-negative / -1) SHALL produce lo = most-negative value and hi = 0, with no trap.
REQ-029 Requests presented while not in IDLE are ignored (req_ready = 0).

Reset
REQ-030 While resetn = 0 at an edge: state = IDLE, hi = lo = 0, res_valid = div_start = dz = 0, and div_a = div_b = 0.
REQ-031 Reset in any state, including mid-WAIT, SHALL abandon the operation, write no result and give req_ready = 1 in the cycle after reset is released; the divider is reset from the same resetn.

Structure
REQ-032 Package mdu_pkg SHALL hold the XLEN default and the state enumeration typedef.
REQ-033 The conditional two's-complement negate/abs function SHALL be one combinational sub-module, div_sign_fix, instantiated for the operand path and for the result path.
REQ-034 The divider SHALL be external to this block and connected through the div_* ports only.

Verification
REQ-035 Unsigned 100 / 7 -> lo = 14, hi = 2, res_valid at the latency of REQ-025, exactly one div_start pulse.
REQ-036 Signed -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; signed 7 / -2 -> lo = 0xFFFFFFFD, hi = 1.
REQ-037 Signed 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, dz = 0.
REQ-038 5 / 0 (both signed and unsigned) -> lo = 0xFFFFFFFF, hi = 5, dz = 1, res_valid per REQ-026, div_start never asserted.
REQ-039 resetn low for 1 cycle mid-WAIT -> hi = lo = 0, no res_valid pulse, req_ready = 1 after release; then a new divide 9 / 3 gives lo = 3, hi = 0.
REQ-040 Back-to-back: 2nd request held valid during the res_valid cycle -> accepted that cycle, both results correct, stall low for only that one cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: default operand width
// and the divide issue controller state encoding.
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIX   = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Bundle of the request handshake, divider bus and result signals of the
// divide issue controller. The controller sits on the slave modport; the
// requester plus the attached divider sit on the master modport.
interface div_issue_ctrl_if
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic              req_valid;
  logic              req_ready;
  logic              req_signed;
  logic [XLEN-1:0]   req_a;
  logic [XLEN-1:0]   req_b;

  logic              div_start;
  logic [2*XLEN-1:0] div_a;
  logic [XLEN-1:0]   div_b;
  logic              div_busy;
  logic [2*XLEN-1:0] div_q;
  logic [XLEN-1:0]   div_r;

  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic              res_valid;
  logic              stall;
  logic              dz;

  modport slave (
    input  req_valid, req_signed, req_a, req_b,
    input  div_busy, div_q, div_r,
    output req_ready, div_start, div_a, div_b,
    output hi, lo, res_valid, stall, dz
  );

  modport master (
    output req_valid, req_signed, req_a, req_b,
    output div_busy, div_q, div_r,
    input  req_ready, div_start, div_a, div_b,
    input  hi, lo, res_valid, stall, dz
  );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: used both to take operand magnitudes
// and to restore the sign of quotient/remainder. Wraps modulo 2^W, so the
// most-negative value maps onto itself.
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? -x : x;

endmodule

// File: rtl/div_issue_ctrl.sv
// Divide issue controller: accepts a DIV/DIVU request, feeds operand
// magnitudes to an external unsigned divider, and writes sign-corrected
// quotient/remainder into lo/hi. Divide by zero bypasses the divider.
module div_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  div_issue_ctrl_if.slave bus
);

  div_state_t      state;
  div_state_t      state_next;
  logic            accept;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  logic [XLEN-1:0] a_raw;
  logic            qneg;
  logic            rneg;
  logic            dz_pend;

  assign a_neg = bus.req_signed & bus.req_a[XLEN-1];
  assign b_neg = bus.req_signed & bus.req_b[XLEN-1];

  div_sign_fix #(.W(XLEN)) u_abs_a (.neg(a_neg), .x(bus.req_a),            .y(a_mag));
  div_sign_fix #(.W(XLEN)) u_abs_b (.neg(b_neg), .x(bus.req_b),            .y(b_mag));
  div_sign_fix #(.W(XLEN)) u_fix_q (.neg(qneg),  .x(bus.div_q[XLEN-1:0]), .y(q_fix));
  div_sign_fix #(.W(XLEN)) u_fix_r (.neg(rneg),  .x(bus.div_r),            .y(r_fix));

  // State register; reset abandons whatever operation is in flight.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and handshake/strobe outputs decoded from the current state.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.stall     = 1'b1;
    bus.div_start = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.stall     = 1'b0;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = (bus.req_b == '0) ? FIX : ISSUE;
        end
      end
      ISSUE: begin
        bus.div_start = 1'b1;
        state_next    = WAIT;
      end
      WAIT: begin
        if (!bus.div_busy) state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latch on accept and result write-back while leaving FIX.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.div_a     <= '0;
      bus.div_b     <= '0;
      bus.hi        <= '0;
      bus.lo        <= '0;
      bus.res_valid <= 1'b0;
      bus.dz        <= 1'b0;
      a_raw         <= '0;
      qneg          <= 1'b0;
      rneg          <= 1'b0;
      dz_pend       <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      if (accept) begin
        bus.div_a <= {{XLEN{1'b0}}, a_mag};
        bus.div_b <= b_mag;
        a_raw     <= bus.req_a;
        qneg      <= a_neg ^ b_neg;
        rneg      <= a_neg;
        dz_pend   <= (bus.req_b == '0);
      end
      if (state == FIX) begin
        bus.res_valid <= 1'b1;
        if (dz_pend) begin
          bus.lo <= '1;
          bus.hi <= a_raw;
          bus.dz <= 1'b1;
        end else begin
          bus.lo <= q_fix;
          bus.hi <= r_fix;
          bus.dz <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider attached to the div_* bus,
// a transaction-level reference model, a per-cycle compare process,
// directed literal cases and a randomized request phase.
module tb_div_issue_ctrl;

  localparam int XLEN = 32;

  logic clk;
  logic resetn;

  div_issue_ctrl_if #(.XLEN(XLEN)) bus ();

  div_issue_ctrl #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Attached unsigned divider: busy for 2*XLEN cycles after the start pulse,
  // results are garbage until busy drops.
  logic [63:0] dv_a;
  logic [31:0] dv_b;
  int          dv_rem;

  always @(posedge clk) begin
    if (!resetn) begin
      dv_rem       <= 0;
      bus.div_busy <= 1'b0;
      bus.div_q    <= '0;
      bus.div_r    <= '0;
    end else if (bus.div_start === 1'b1) begin
      dv_a         <= bus.div_a;
      dv_b         <= bus.div_b;
      dv_rem       <= 2 * XLEN;
      bus.div_busy <= 1'b1;
      bus.div_q    <= {$urandom, $urandom};
      bus.div_r    <= $urandom;
    end else if (dv_rem > 0) begin
      dv_rem <= dv_rem - 1;
      if (dv_rem == 1) begin
        bus.div_busy <= 1'b0;
        if (dv_b == 0) begin
          bus.div_q <= '1;
          bus.div_r <= dv_a[31:0];
        end else begin
          bus.div_q <= dv_a / {32'd0, dv_b};
          bus.div_r <= 32'(dv_a % {32'd0, dv_b});
        end
      end
    end
  end

  // Reference arithmetic: DIV/DIVU with truncation toward zero, remainder
  // taking the dividend's sign, divide by zero giving all-ones / dividend.
  function automatic void model_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] lo, output logic [31:0] hi, output bit dz,
                                    output logic [63:0] amag, output logic [31:0] bmag);
    longint sa, sb, q, r;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    amag = (sa < 0) ? 64'(-sa) : 64'(sa);
    bmag = (sb < 0) ? 32'(-sb) : 32'(sb);
    if (sb == 0) begin
      lo = '1;
      hi = a;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = 32'(q);
      hi = 32'(r);
      dz = 1'b0;
    end
  endfunction

  int          edge_n     = 0;
  bit          model_live = 0;
  bit          m_busy     = 0;
  int          done_edge  = 0;
  bit          start_exp  = 0;
  bit          exp_rv     = 0;
  logic [31:0] exp_hi     = '0;
  logic [31:0] exp_lo     = '0;
  bit          exp_dz     = 0;
  logic [31:0] pend_hi, pend_lo;
  bit          pend_dz;
  logic [63:0] pend_amag;
  logic [31:0] pend_bmag;

  // Transaction model: one operation in flight, result due a fixed number
  // of edges after acceptance.
  always @(posedge clk) begin
    edge_n++;
    model_live = 1;
    exp_rv     = 0;
    start_exp  = 0;
    if (!resetn) begin
      m_busy = 0;
      exp_hi = '0;
      exp_lo = '0;
      exp_dz = 0;
    end else if (m_busy) begin
      if (edge_n == done_edge) begin
        m_busy = 0;
        exp_rv = 1;
        exp_hi = pend_hi;
        exp_lo = pend_lo;
        exp_dz = pend_dz;
      end
    end else if (bus.req_valid === 1'b1) begin
      model_div(bus.req_signed, bus.req_a, bus.req_b, pend_lo, pend_hi, pend_dz, pend_amag, pend_bmag);
      m_busy = 1;
      if (pend_dz) done_edge = edge_n + 1;
      else begin
        done_edge = edge_n + 2 * XLEN + 3;
        start_exp = 1;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("req_ready", bus.req_ready, !m_busy);
      checkOutput("stall", bus.stall, m_busy);
      checkOutput("div_start", bus.div_start, start_exp);
      checkOutput("res_valid", bus.res_valid, exp_rv);
      checkOutput("hi", bus.hi, exp_hi);
      checkOutput("lo", bus.lo, exp_lo);
      checkOutput("dz", bus.dz, exp_dz);
      if (start_exp) begin
        checkOutput("div_a", bus.div_a, pend_amag);
        checkOutput("div_b", bus.div_b, pend_bmag);
      end
    end
  end

  // Present one request now; returns just after the accepting edge.
  task automatic applyStimulus(input bit sg, input logic [31:0] a, input logic [31:0] b);
    bus.req_signed = sg;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
  endtask

  // Wait (bounded) for the result pulse and pin it against literal values.
  task automatic waitResult(input string tag, input logic [31:0] elo, input logic [31:0] ehi,
                            input bit edz, input int elat, input int estarts);
    int lat    = 0;
    int starts = 0;
    bit seen   = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (bus.div_start === 1'b1) starts++;
      if (bus.res_valid === 1'b1) begin
        seen = 1;
        lat  = k;
      end
    end
    checkOutput({tag, " result seen"}, seen, 1);
    if (seen) begin
      checkOutput({tag, " latency"}, lat, elat);
      checkOutput({tag, " lo"}, bus.lo, elo);
      checkOutput({tag, " hi"}, bus.hi, ehi);
      checkOutput({tag, " dz"}, bus.dz, edz);
      checkOutput({tag, " start pulses"}, starts, estarts);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = $urandom_range(1, 20);
      4: begin
        v = $urandom_range(1, 20);
        v = -v;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  int rv_seen;

  initial begin
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset hi", bus.hi, 0);
    checkOutput("reset lo", bus.lo, 0);
    checkOutput("reset req_ready", bus.req_ready, 1);
    checkOutput("reset res_valid", bus.res_valid, 0);
    checkOutput("reset div_start", bus.div_start, 0);
    checkOutput("reset dz", bus.dz, 0);
    checkOutput("reset stall", bus.stall, 0);
    resetn = 1'b1;

    @(negedge clk);
    applyStimulus(0, 32'd100, 32'd7);
    waitResult("u100/7", 32'd14, 32'd2, 0, 67, 1);

    repeat (2) @(negedge clk);
    applyStimulus(1, 32'hFFFF_FFF9, 32'd2);
    waitResult("s-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 67, 1);

    repeat (2) @(negedge clk);
    applyStimulus(1, 32'd7, 32'hFFFF_FFFE);
    waitResult("s7/-2", 32'hFFFF_FFFD, 32'd1, 0, 67, 1);

    repeat (2) @(negedge clk);
    applyStimulus(1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitResult("s_ovf", 32'h8000_0000, 32'd0, 0, 67, 1);

    repeat (2) @(negedge clk);
    applyStimulus(1, 32'd5, 32'd0);
    waitResult("s5/0", 32'hFFFF_FFFF, 32'd5, 1, 1, 0);

    repeat (2) @(negedge clk);
    applyStimulus(0, 32'd5, 32'd0);
    waitResult("u5/0", 32'hFFFF_FFFF, 32'd5, 1, 1, 0);

    // Back-to-back: second request offered in the result cycle.
    repeat (2) @(negedge clk);
    applyStimulus(0, 32'd100, 32'd7);
    waitResult("b2b first", 32'd14, 32'd2, 0, 67, 1);
    checkOutput("b2b req_ready", bus.req_ready, 1);
    checkOutput("b2b stall", bus.stall, 0);
    applyStimulus(1, 32'hFFFF_FFF9, 32'd2);
    waitResult("b2b second", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 67, 1);

    // Reset in the middle of WAIT abandons the divide.
    repeat (2) @(negedge clk);
    applyStimulus(0, 32'd100, 32'd7);
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("midreset hi", bus.hi, 0);
    checkOutput("midreset lo", bus.lo, 0);
    checkOutput("midreset req_ready", bus.req_ready, 1);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("post-release req_ready", bus.req_ready, 1);
    rv_seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) rv_seen++;
    end
    checkOutput("abandoned res_valid pulses", rv_seen, 0);
    applyStimulus(0, 32'd9, 32'd3);
    waitResult("u9/3", 32'd3, 32'd0, 0, 67, 1);

    // Randomized requests, offered regardless of req_ready.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      bus.req_valid  = ($urandom_range(0, 3) == 0);
      bus.req_signed = 1'($urandom_range(0, 1));
      bus.req_a      = pickOperand();
      bus.req_b      = pickOperand();
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (150) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
